mem_stage: RTL and testbench

Memory (M) stage of the five-stage MIPS pipeline: the E/M pipeline register, data-bus access with variable-latency handshake, store byte-enable generation, load alignment/extension and address-exception detection. Sits between the execute stage and the M/W register, and drives every `*_M_o` input of that register plus the M-stage forwarding taps.

---
 rtl/mem_stage.sv | 240 ++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage of the five-stage MIPS pipeline.
// Holds the E/M pipeline register, drives the data bus with a
// request/ready handshake, builds store byte enables and write data,
// aligns and extends load data, and flags misaligned accesses.
// The pipeline stalls until the bus answers. A flush input abandons
// any access that is in flight.

module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic [3:0]  memOp_E_o,
    input  logic [31:0] result_E_o,
    input  logic [31:0] rt_E_o,
    input  logic [31:0] md_E_o,
    input  logic [31:0] PCn_E_o,
    input  logic [31:0] OP_E_o,
    input  logic        regWrite_E_o,
    input  logic [4:0]  A3_E_o,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_byteen,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    output logic [31:0] memory_M_o,
    output logic [31:0] result_M_o,
    output logic [31:0] md_M_o,
    output logic [31:0] PCn_M_o,
    output logic [31:0] OP_M_o,
    output logic        regWrite_M_o,
    output logic [4:0]  A3_M_o,
    output logic [4:0]  excCode_M,
    output logic        M_stall,
    output logic [31:0] M_forward,
    output logic        M_regWrite,
    output logic [4:0]  M_A3
);

    // Memory operation encoding carried down from decode.
    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LW   = 4'd1,
        OP_LH   = 4'd2,
        OP_LHU  = 4'd3,
        OP_LB   = 4'd4,
        OP_LBU  = 4'd5,
        OP_SW   = 4'd6,
        OP_SH   = 4'd7,
        OP_SB   = 4'd8
    } memOp_t;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    // Pipeline register contents.
    logic [3:0]  r_memOp;
    logic [31:0] r_result;
    logic [31:0] r_rt;
    logic [31:0] r_md;
    logic [31:0] r_PCn;
    logic [31:0] r_OP;
    logic [4:0]  r_A3;
    logic        r_regWrite;
    logic        r_done;
    logic [31:0] r_rdata;

    // Decode results.
    logic        w_isLoad;
    logic        w_isStore;
    logic        w_misaligned;
    logic        w_exc;
    logic        w_access;
    logic [3:0]  w_byteen;
    logic [31:0] w_wdata;
    logic [31:0] w_loadData;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Classify the held operation and test its address alignment.
    always_comb begin
        w_isLoad     = 1'b0;
        w_isStore    = 1'b0;
        w_misaligned = 1'b0;
        case (r_memOp)
            OP_LW: begin
                w_isLoad     = 1'b1;
                w_misaligned = (r_result[1:0] != 2'b00);
            end
            OP_LH, OP_LHU: begin
                w_isLoad     = 1'b1;
                w_misaligned = r_result[0];
            end
            OP_LB, OP_LBU: begin
                w_isLoad     = 1'b1;
            end
            OP_SW: begin
                w_isStore    = 1'b1;
                w_misaligned = (r_result[1:0] != 2'b00);
            end
            OP_SH: begin
                w_isStore    = 1'b1;
                w_misaligned = r_result[0];
            end
            OP_SB: begin
                w_isStore    = 1'b1;
            end
            default: begin
                w_isLoad     = 1'b0;
                w_isStore    = 1'b0;
                w_misaligned = 1'b0;
            end
        endcase
    end

    // A faulting access never reaches the bus.
    // A finished access drops its request, which ends the stall.
    assign w_exc    = (w_isLoad | w_isStore) & w_misaligned;
    assign w_access = (w_isLoad | w_isStore) & ~w_exc & ~r_done;

    // Store lane enables and replicated write data for the addressed lane(s).
    always_comb begin
        w_byteen = 4'b0000;
        w_wdata  = r_rt;
        case (r_memOp)
            OP_SW: begin
                w_byteen = 4'b1111;
                w_wdata  = r_rt;
            end
            OP_SH: begin
                w_byteen = r_result[1] ? 4'b1100 : 4'b0011;
                w_wdata  = {2{r_rt[15:0]}};
            end
            OP_SB: begin
                w_byteen = 4'b0001 << r_result[1:0];
                w_wdata  = {4{r_rt[7:0]}};
            end
            default: begin
                w_byteen = 4'b0000;
                w_wdata  = r_rt;
            end
        endcase
    end

    // Pick the addressed byte/halfword out of the captured word and extend it.
    always_comb begin
        w_half = r_result[1] ? r_rdata[31:16] : r_rdata[15:0];
        case (r_result[1:0])
            2'd0:    w_byte = r_rdata[7:0];
            2'd1:    w_byte = r_rdata[15:8];
            2'd2:    w_byte = r_rdata[23:16];
            default: w_byte = r_rdata[31:24];
        endcase
        w_loadData = 32'd0;
        if (!w_exc) begin
            case (r_memOp)
                OP_LW:   w_loadData = r_rdata;
                OP_LH:   w_loadData = {{16{w_half[15]}}, w_half};
                OP_LHU:  w_loadData = {16'd0, w_half};
                OP_LB:   w_loadData = {{24{w_byte[7]}}, w_byte};
                OP_LBU:  w_loadData = {24'd0, w_byte};
                default: w_loadData = 32'd0;
            endcase
        end
    end

    // E/M register.
    // A flush clears it.
    // A stall holds it while the bus answer is captured.
    // Otherwise the next instruction is loaded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_memOp    <= 4'd0;
            r_result   <= 32'd0;
            r_rt       <= 32'd0;
            r_md       <= 32'd0;
            r_PCn      <= 32'd0;
            r_OP       <= 32'd0;
            r_A3       <= 5'd0;
            r_regWrite <= 1'b0;
            r_done     <= 1'b0;
            r_rdata    <= 32'd0;
        end else if (Req) begin
            r_memOp    <= 4'd0;
            r_result   <= 32'd0;
            r_rt       <= 32'd0;
            r_md       <= 32'd0;
            r_PCn      <= 32'd0;
            r_OP       <= 32'd0;
            r_A3       <= 5'd0;
            r_regWrite <= 1'b0;
            r_done     <= 1'b0;
            r_rdata    <= 32'd0;
        end else if (w_access) begin
            if (m_ready) begin
                r_done  <= 1'b1;
                r_rdata <= m_rdata;
            end
        end else begin
            r_memOp    <= memOp_E_o;
            r_result   <= result_E_o;
            r_rt       <= rt_E_o;
            r_md       <= md_E_o;
            r_PCn      <= PCn_E_o;
            r_OP       <= OP_E_o;
            r_A3       <= A3_E_o;
            r_regWrite <= regWrite_E_o;
            r_done     <= 1'b0;
        end
    end

    // Data bus request.
    assign m_req    = w_access;
    assign m_we     = w_access & w_isStore;
    assign m_addr   = w_access ? {r_result[31:2], 2'b00} : 32'd0;
    assign m_byteen = w_access ? w_byteen : 4'b0000;
    assign m_wdata  = w_access ? w_wdata : 32'd0;

    assign M_stall  = w_access;

    // Toward W a waiting instruction is presented as a bubble.
    // A faulting instruction never writes its destination.
    assign memory_M_o   = w_access ? 32'd0 : w_loadData;
    assign result_M_o   = w_access ? 32'd0 : r_result;
    assign md_M_o       = w_access ? 32'd0 : r_md;
    assign PCn_M_o      = w_access ? 32'd0 : r_PCn;
    assign OP_M_o       = w_access ? 32'd0 : r_OP;
    assign regWrite_M_o = w_access ? 1'b0 : (r_regWrite & ~w_exc);
    assign A3_M_o       = w_access ? 5'd0 : r_A3;
    assign excCode_M    = ~w_exc ? EXC_NONE : (w_isLoad ? EXC_ADEL : EXC_ADES);

    // Forwarding taps.
    // These are never bubbled, because the hazard unit already stalls on a load in M.
    assign M_forward  = r_result;
    assign M_regWrite = r_regWrite;
    assign M_A3       = r_A3;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage.
// Hand-computed vectors cover reset, a plain ALU instruction, and loads
// with extension. They also cover store lane generation, address
// exceptions, flush during a wait, and asynchronous reset mid-access.

module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        Req;
    logic [3:0]  memOp_E_o;
    logic [31:0] result_E_o;
    logic [31:0] rt_E_o;
    logic [31:0] md_E_o;
    logic [31:0] PCn_E_o;
    logic [31:0] OP_E_o;
    logic        regWrite_E_o;
    logic [4:0]  A3_E_o;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_byteen;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic [31:0] memory_M_o;
    logic [31:0] result_M_o;
    logic [31:0] md_M_o;
    logic [31:0] PCn_M_o;
    logic [31:0] OP_M_o;
    logic        regWrite_M_o;
    logic [4:0]  A3_M_o;
    logic [4:0]  excCode_M;
    logic        M_stall;
    logic [31:0] M_forward;
    logic        M_regWrite;
    logic [4:0]  M_A3;

    int checkCount = 0;
    int errorCount = 0;

    mem_stage dut (
        .clk(clk), .reset(reset), .Req(Req),
        .memOp_E_o(memOp_E_o), .result_E_o(result_E_o), .rt_E_o(rt_E_o),
        .md_E_o(md_E_o), .PCn_E_o(PCn_E_o), .OP_E_o(OP_E_o),
        .regWrite_E_o(regWrite_E_o), .A3_E_o(A3_E_o),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_byteen(m_byteen), .m_ready(m_ready), .m_rdata(m_rdata),
        .memory_M_o(memory_M_o), .result_M_o(result_M_o), .md_M_o(md_M_o),
        .PCn_M_o(PCn_M_o), .OP_M_o(OP_M_o), .regWrite_M_o(regWrite_M_o),
        .A3_M_o(A3_M_o), .excCode_M(excCode_M), .M_stall(M_stall),
        .M_forward(M_forward), .M_regWrite(M_regWrite), .M_A3(M_A3)
    );

    // Free-running clock with rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value and log a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one instruction on the E-stage outputs.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr,
                                 input logic [31:0] rt, input logic rw,
                                 input logic [4:0] a3, input logic [31:0] pcn);
        memOp_E_o    = op;
        result_E_o   = addr;
        rt_E_o       = rt;
        md_E_o       = addr ^ 32'h5A5A_0000;
        PCn_E_o      = pcn;
        OP_E_o       = 32'h8C00_0000 | {28'd0, op};
        regWrite_E_o = rw;
        A3_E_o       = a3;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Enter a memory op and answer it so that its access completes after 'lat' stall cycles.
    task automatic runAccess(input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] rt, input logic [31:0] word, input int lat);
        applyStimulus(op, addr, rt, 1'b1, 5'd10, 32'h0000_4000);
        tick();
        applyStimulus(4'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        for (int i = 1; i < lat; i++) tick();
        m_ready = 1'b1;
        m_rdata = word;
        tick();
        m_ready = 1'b0;
        m_rdata = 32'd0;
    endtask

    initial begin
        reset = 1'b0;
        Req = 1'b0;
        m_ready = 1'b0;
        m_rdata = 32'd0;
        applyStimulus(4'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #3;
        checkOutput("rst_stall", {31'd0, M_stall}, 32'd0);
        checkOutput("rst_req", {31'd0, m_req}, 32'd0);
        checkOutput("rst_fwd", M_forward, 32'd0);
        checkOutput("rst_rw", {31'd0, regWrite_M_o}, 32'd0);
        checkOutput("rst_exc", {27'd0, excCode_M}, 32'd0);
        #5 reset = 1'b1;

        // addi: passes straight through with no stall.
        applyStimulus(4'd0, 32'd5, 32'd0, 1'b1, 5'd8, 32'h0000_3004);
        tick();
        checkOutput("addi_stall", {31'd0, M_stall}, 32'd0);
        checkOutput("addi_result", result_M_o, 32'd5);
        checkOutput("addi_rw", {31'd0, regWrite_M_o}, 32'd1);
        checkOutput("addi_a3", {27'd0, A3_M_o}, 32'd8);
        checkOutput("addi_fwd", M_forward, 32'd5);

        // lw at 0x100 with the bus answering after 2 cycles.
        applyStimulus(4'd1, 32'h100, 32'd0, 1'b1, 5'd9, 32'h0000_3008);
        tick();
        applyStimulus(4'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("lw_req1", {31'd0, m_req}, 32'd1);
        checkOutput("lw_stall1", {31'd0, M_stall}, 32'd1);
        checkOutput("lw_addr", m_addr, 32'h100);
        checkOutput("lw_we", {31'd0, m_we}, 32'd0);
        checkOutput("lw_byteen", {28'd0, m_byteen}, 32'd0);
        checkOutput("lw_bubble_res", result_M_o, 32'd0);
        checkOutput("lw_bubble_rw", {31'd0, regWrite_M_o}, 32'd0);
        checkOutput("lw_fwd", M_forward, 32'h100);
        tick();
        checkOutput("lw_stall2", {31'd0, M_stall}, 32'd1);
        m_ready = 1'b1;
        m_rdata = 32'hDEAD_BEEF;
        tick();
        m_ready = 1'b0;
        m_rdata = 32'd0;
        checkOutput("lw_stall_end", {31'd0, M_stall}, 32'd0);
        checkOutput("lw_req_end", {31'd0, m_req}, 32'd0);
        checkOutput("lw_data", memory_M_o, 32'hDEAD_BEEF);
        checkOutput("lw_rw", {31'd0, regWrite_M_o}, 32'd1);
        checkOutput("lw_a3", {27'd0, A3_M_o}, 32'd9);
        checkOutput("lw_pcn", PCn_M_o, 32'h0000_3008);
        checkOutput("lw_op", OP_M_o, 32'h8C00_0001);
        checkOutput("lw_md", md_M_o, 32'h5A5A_0100);
        tick();
        checkOutput("nop_rw", {31'd0, regWrite_M_o}, 32'd0);

        // Sub-word loads with extension.
        runAccess(4'd4, 32'h103, 32'd0, 32'h80FF_0000, 1);
        checkOutput("lb_data", memory_M_o, 32'hFFFF_FF80);
        runAccess(4'd5, 32'h103, 32'd0, 32'h80FF_0000, 1);
        checkOutput("lbu_data", memory_M_o, 32'h0000_0080);
        runAccess(4'd2, 32'h102, 32'd0, 32'h80FF_0000, 1);
        checkOutput("lh_hi", memory_M_o, 32'hFFFF_80FF);
        runAccess(4'd3, 32'h102, 32'd0, 32'h80FF_0000, 1);
        checkOutput("lhu_hi", memory_M_o, 32'h0000_80FF);
        runAccess(4'd4, 32'h101, 32'd0, 32'h1234_5678, 1);
        checkOutput("lb_pos", memory_M_o, 32'h0000_0056);

        // Stores: lanes and data are checked while the request is up.
        applyStimulus(4'd7, 32'h102, 32'h1234_ABCD, 1'b0, 5'd0, 32'd0);
        tick();
        applyStimulus(4'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("sh_byteen", {28'd0, m_byteen}, 32'hC);
        checkOutput("sh_wdata", m_wdata, 32'hABCD_ABCD);
        checkOutput("sh_we", {31'd0, m_we}, 32'd1);
        checkOutput("sh_addr", m_addr, 32'h100);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        checkOutput("sh_stall_end", {31'd0, M_stall}, 32'd0);

        applyStimulus(4'd8, 32'h101, 32'h0000_00EF, 1'b0, 5'd0, 32'd0);
        tick();
        applyStimulus(4'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("sb_byteen", {28'd0, m_byteen}, 32'h2);
        checkOutput("sb_wdata", m_wdata, 32'hEFEF_EFEF);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;

        applyStimulus(4'd6, 32'h104, 32'hCAFE_F00D, 1'b0, 5'd0, 32'd0);
        tick();
        applyStimulus(4'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("sw_byteen", {28'd0, m_byteen}, 32'hF);
        checkOutput("sw_wdata", m_wdata, 32'hCAFE_F00D);
        checkOutput("sw_addr", m_addr, 32'h104);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;

        // Misaligned accesses fault without touching the bus.
        applyStimulus(4'd1, 32'h101, 32'd0, 1'b1, 5'd7, 32'd0);
        tick();
        applyStimulus(4'd7, 32'h103, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("adel_code", {27'd0, excCode_M}, 32'd4);
        checkOutput("adel_req", {31'd0, m_req}, 32'd0);
        checkOutput("adel_stall", {31'd0, M_stall}, 32'd0);
        checkOutput("adel_rw", {31'd0, regWrite_M_o}, 32'd0);
        tick();
        applyStimulus(4'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("ades_code", {27'd0, excCode_M}, 32'd5);
        checkOutput("ades_req", {31'd0, m_req}, 32'd0);
        tick();

        // Flush during the second wait cycle of a lw.
        applyStimulus(4'd1, 32'h200, 32'd0, 1'b1, 5'd11, 32'h0000_5000);
        tick();
        applyStimulus(4'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        checkOutput("req_stall_pre", {31'd0, M_stall}, 32'd1);
        Req = 1'b1;
        tick();
        Req = 1'b0;
        checkOutput("req_mreq", {31'd0, m_req}, 32'd0);
        checkOutput("req_stall", {31'd0, M_stall}, 32'd0);
        checkOutput("req_fwd", M_forward, 32'd0);
        checkOutput("req_rw", {31'd0, regWrite_M_o}, 32'd0);
        checkOutput("req_pcn", PCn_M_o, 32'd0);
        m_ready = 1'b1;
        m_rdata = 32'h1111_2222;
        tick();
        m_ready = 1'b0;
        m_rdata = 32'd0;
        checkOutput("late_ready_req", {31'd0, m_req}, 32'd0);
        checkOutput("late_ready_mem", memory_M_o, 32'd0);

        // Flush and bus answer in the same cycle: the flush wins.
        applyStimulus(4'd1, 32'h204, 32'd0, 1'b1, 5'd12, 32'd0);
        tick();
        applyStimulus(4'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        Req = 1'b1;
        m_ready = 1'b1;
        m_rdata = 32'h3333_4444;
        tick();
        Req = 1'b0;
        m_ready = 1'b0;
        m_rdata = 32'd0;
        checkOutput("req_win_mem", memory_M_o, 32'd0);
        checkOutput("req_win_rw", {31'd0, regWrite_M_o}, 32'd0);

        // Asynchronous reset in the middle of an access.
        applyStimulus(4'd1, 32'h300, 32'd0, 1'b1, 5'd13, 32'd0);
        tick();
        applyStimulus(4'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("arst_pre_stall", {31'd0, M_stall}, 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("arst_req", {31'd0, m_req}, 32'd0);
        checkOutput("arst_stall", {31'd0, M_stall}, 32'd0);
        checkOutput("arst_fwd", M_forward, 32'd0);
        #2 reset = 1'b1;
        applyStimulus(4'd0, 32'd77, 32'd0, 1'b1, 5'd3, 32'd0);
        tick();
        checkOutput("resume_res", result_M_o, 32'd77);
        checkOutput("resume_rw", {31'd0, regWrite_M_o}, 32'd1);
        runAccess(4'd1, 32'h308, 32'd0, 32'h0BAD_F00D, 1);
        checkOutput("resume_lw", memory_M_o, 32'h0BAD_F00D);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
